// File: rtl/risc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC control unit.
//  opcode_e : named opcodes (R-type occupies 0010..1010, 1110/1111 are undefined)
//  state_e  : main sequencer states
//  pc_src_e : PC source select encoding
//  ALUOP_*  : ALU-class codes consumed by the ALU control decoder
package risc_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LD  = 4'b0000,
        OP_ST  = 4'b0001,
        OP_BEQ = 4'b1011,
        OP_BNE = 4'b1100,
        OP_JMP = 4'b1101
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS2  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= 4'b0010) && (op <= 4'b1010);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:1] == 3'b111;
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-handshake wait timer.
//  clk, reset_n : clock, synchronous active-low reset
//  clear        : force count to zero (wins over enable)
//  enable       : one request cycle waited without ack
//  count        : cycles waited so far
//  timeout      : this waiting cycle is the TIMEOUT_CYC-th one
module ctrl_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned TMR_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [TMR_W-1:0] count,
    output logic             timeout
);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flags the cycle in which the count would reach TIMEOUT_CYC; an ack in
    // that cycle deasserts enable, so ack wins over the timeout.
    assign timeout = enable && (count == TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory and drives datapath strobes.
//  inputs : clk, reset_n, ir_opcode, zero_flag, imem_ack, dmem_ack
//  outputs: imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
//           alu_op, alu_opcode, alu_src, reg_dst, reg_write, mem_to_reg,
//           illegal_op (1-cycle pulse), bus_error (sticky until reset)
module multicycle_ctrl_fsm
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned TMR_W       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                zero_flag,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic [OPCODE_W-1:0] alu_opcode,
    output logic                alu_src,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic                bus_error
);

    state_e              state_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic                bus_error_q;
    logic [TMR_W-1:0]    tmr_count;
    logic                tmr_timeout;
    logic                tmr_clear;
    logic                tmr_enable;
    logic                ack_now;
    logic [1:0]          class_aluop;

    always_comb begin
        ack_now    = 1'b0;
        tmr_enable = 1'b0;
        if (state_q == FETCH) begin
            ack_now    = imem_ack;
            tmr_enable = !imem_ack;
        end else if (state_q == MEM) begin
            ack_now    = dmem_ack;
            tmr_enable = !dmem_ack;
        end
        // Clearing outside the wait states, on ack and on timeout guarantees
        // the count is zero on every entry into FETCH or MEM.
        tmr_clear = !((state_q == FETCH) || (state_q == MEM)) || ack_now || tmr_timeout;
    end

    ctrl_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .count  (tmr_count),
        .timeout(tmr_timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            opcode_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            if (tmr_timeout) begin
                bus_error_q <= 1'b1;
            end
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    opcode_q <= ir_opcode;
                    if ((ir_opcode == OP_JMP) || is_illegal(ir_opcode)) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_rtype(opcode_q)) begin
                        state_q <= WB;
                    end else if (is_mem(opcode_q)) begin
                        state_q <= MEM;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        state_q <= (opcode_q == OP_LD) ? WB : FETCH;
                    end else if (tmr_timeout) begin
                        state_q <= FETCH;
                    end
                end
                WB:      state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        if (is_mem(opcode_q)) begin
            class_aluop = ALUOP_ADD;
        end else if (is_branch(opcode_q)) begin
            class_aluop = ALUOP_SUB;
        end else begin
            class_aluop = ALUOP_RTYPE;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS2;
        alu_op     = ALUOP_RTYPE;
        alu_opcode = opcode_q;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                pc_write = imem_ack;
            end
            DECODE: begin
                if (ir_opcode == OP_JMP) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
                illegal_op = is_illegal(ir_opcode);
            end
            EXEC: begin
                alu_op  = class_aluop;
                alu_src = is_mem(opcode_q);
                if (((opcode_q == OP_BEQ) && zero_flag) ||
                    ((opcode_q == OP_BNE) && !zero_flag)) begin
                    pc_write = 1'b1;
                    pc_src   = PC_BRANCH;
                end
            end
            MEM: begin
                alu_op   = class_aluop;
                dmem_req = 1'b1;
                dmem_we  = (opcode_q == OP_ST);
            end
            WB: begin
                alu_op     = class_aluop;
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OP_LD);
                reg_dst    = is_rtype(opcode_q);
            end
            default: ;
        endcase
        if (!reset_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_PLUS2;
            alu_op     = ALUOP_RTYPE;
            alu_opcode = '0;
            alu_src    = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] ir_opcode;
    logic       zero_flag;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, alu_op;
    logic [3:0] alu_opcode;
    logic       alu_src, reg_dst, reg_write, mem_to_reg, illegal_op, bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .OPCODE_W   (4),
        .TIMEOUT_CYC(15),
        .TMR_W      (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_opcode (ir_opcode),
        .zero_flag (zero_flag),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_opcode(alu_opcode),
        .alu_src   (alu_src),
        .reg_dst   (reg_dst),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op),
        .bus_error (bus_error)
    );

    // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_src,alu_op,alu_opcode,
    //  alu_src,reg_dst,reg_write,mem_to_reg,illegal_op,bus_error}
    logic [18:0] outs;
    assign outs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_op,
                   alu_opcode, alu_src, reg_dst, reg_write, mem_to_reg, illegal_op, bus_error};

    typedef struct {
        logic        rst_n;
        logic [3:0]  op;
        logic        z;
        logic        ia;
        logic        da;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] op, input logic z,
                       input logic ia, input logic da,
                       input logic imr, input logic dmr, input logic we,
                       input logic irw, input logic pcw, input logic [1:0] pcs,
                       input logic [1:0] aop, input logic [3:0] aopc,
                       input logic src, input logic dst, input logic rw,
                       input logic m2r, input logic ill, input logic be);
        vec_t v;
        v.rst_n = r; v.op = op; v.z = z; v.ia = ia; v.da = da;
        v.exp = {imr, dmr, we, irw, pcw, pcs, aop, aopc, src, dst, rw, m2r, ill, be};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] op, input logic z,
                         input logic ia, input logic da);
        @(negedge clk);
        reset_n = r; ir_opcode = op; zero_flag = z; imem_ack = ia; dmem_ack = da;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; ir_opcode = '0; zero_flag = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

        // reset
        add(0,4'h0,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        add(0,4'h0,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        // ADD: F(ack) D E W, then FETCH again 4 cycles after ack
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        add(1,4'h2,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h2,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h2,0,1,1,0,0,0);
        add(1,4'h0,0,0,0, 1,0,0,0,0,2'd0,2'd0,4'h2,0,0,0,0,0,0);
        // LD with dmem_ack delayed 3 cycles
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'h2,0,0,0,0,0,0);
        add(1,4'h0,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h2,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd2,4'h0,1,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,1,0,0,0,2'd0,2'd2,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,1,0,0,0,2'd0,2'd2,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,1,0,0,0,2'd0,2'd2,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,1, 0,1,0,0,0,2'd0,2'd2,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd2,4'h0,0,0,1,1,0,0);
        // ST, zero-wait
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        add(1,4'h1,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h0,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd2,4'h1,1,0,0,0,0,0);
        add(1,4'hF,0,0,1, 0,1,1,0,0,2'd0,2'd2,4'h1,0,0,0,0,0,0);
        // BEQ taken (zero=1)
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'h1,0,0,0,0,0,0);
        add(1,4'hB,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'h1,0,0,0,0,0,0);
        add(1,4'hF,1,0,0, 0,0,0,0,1,2'd1,2'd1,4'hB,0,0,0,0,0,0);
        // BNE not taken (zero=1)
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'hB,0,0,0,0,0,0);
        add(1,4'hC,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'hB,0,0,0,0,0,0);
        add(1,4'hF,1,0,0, 0,0,0,0,0,2'd0,2'd1,4'hC,0,0,0,0,0,0);
        // BNE taken (zero=0)
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'hC,0,0,0,0,0,0);
        add(1,4'hC,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'hC,0,0,0,0,0,0);
        add(1,4'hF,0,0,0, 0,0,0,0,1,2'd1,2'd1,4'hC,0,0,0,0,0,0);
        // JMP: jump in DECODE, straight back to FETCH
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'hC,0,0,0,0,0,0);
        add(1,4'hD,0,0,0, 0,0,0,0,1,2'd2,2'd0,4'hC,0,0,0,0,0,0);
        add(1,4'h0,0,1,0, 1,0,0,1,1,2'd0,2'd0,4'hD,0,0,0,0,0,0);
        // illegal 1111: single-cycle pulse, back to FETCH
        add(1,4'hF,0,0,0, 0,0,0,0,0,2'd0,2'd0,4'hD,0,0,0,0,1,0);
        add(1,4'h0,0,0,0, 1,0,0,0,0,2'd0,2'd0,4'hF,0,0,0,0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].op, tbl[i].z, tbl[i].ia, tbl[i].da);
            checks++;
            if (outs !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got %b expected %b", i, outs, tbl[i].exp);
            end
        end

        // Ack arriving on the 15th waiting cycle: no error
        drive(0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 14; i++) drive(1, 4'h0, 0, 0, 0);
        drive(1, 4'h0, 0, 1, 0);
        check("ack15_irw", ir_write, 1);
        drive(1, 4'hD, 0, 0, 0);
        check("ack15_noerr", bus_error, 0);
        check("ack15_jmp", pc_write, 1);

        // imem_ack withheld 15 cycles: bus_error, retry fetch
        for (int i = 0; i < 15; i++) begin
            drive(1, 4'h0, 0, 0, 0);
            if (i == 14) check("to_pre_err", bus_error, 0);
        end
        drive(1, 4'h0, 0, 0, 0);
        check("to_err", bus_error, 1);
        check("to_retry_req", imem_req, 1);
        drive(1, 4'h0, 0, 1, 0);
        check("to_refetch_irw", ir_write, 1);
        drive(1, 4'h2, 0, 0, 0);
        check("to_sticky", bus_error, 1);

        // Reset asserted mid-MEM
        drive(1, 4'h0, 0, 0, 0);              // EXEC (R-type)
        drive(1, 4'h0, 0, 0, 0);              // WB
        drive(1, 4'h0, 0, 1, 0);              // FETCH ack
        drive(1, 4'h0, 0, 0, 0);              // DECODE LD
        drive(1, 4'h0, 0, 0, 0);              // EXEC
        drive(1, 4'h0, 0, 0, 0);              // MEM waiting
        check("rst_mem_req", dmem_req, 1);
        check("rst_mem_err", bus_error, 1);
        drive(0, 4'h0, 0, 0, 0);
        check("rst_gate_dreq", dmem_req, 0);
        drive(0, 4'h0, 0, 0, 0);
        check("rst_dreq", dmem_req, 0);
        check("rst_err_clr", bus_error, 0);
        check("rst_ireq_low", imem_req, 0);
        drive(1, 4'h0, 0, 0, 0);
        check("rel_ireq", imem_req, 1);
        check("rel_dreq", dmem_req, 0);
        check("rel_err", bus_error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
